// File: rtl/input_port_receiver.sv
// Leaf input port: buffers packets for this leaf/port, hands them to the user and returns credits.
// Optional stall counter on input_port_stall_cnt, enabled by defining INPUT_PORT_STALL_CNT_EN.
module input_port_receiver #(
    parameter int NUM_LEAF_BITS         = 6,
    parameter int NUM_PORT_BITS         = 4,
    parameter int NUM_ADDR_BITS         = 7,
    parameter int PAYLOAD_BITS          = 64,
    parameter int NUM_BRAM_ADDR_BITS    = 7,
    parameter int FREESPACE_UPDATE_SIZE = 64,
    parameter int DATA_USER_IN          = 32,
    localparam int PACKET_BITS =
        1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [PACKET_BITS-1:0]        internal_in,
    input  logic [NUM_LEAF_BITS-1:0]      self_leaf_reg,
    input  logic [NUM_PORT_BITS-1:0]      self_port_reg,
    input  logic [NUM_LEAF_BITS-1:0]      src_leaf_reg,
    input  logic [NUM_PORT_BITS-1:0]      src_port_reg,
    input  logic                          is_done_mode,
    output logic [DATA_USER_IN-1:0]       dout_interface2user,
    output logic                          vld_interface2user,
    input  logic                          ack_user2interface,
    output logic [PACKET_BITS-1:0]        internal_out,
    output logic                          empty,
    input  logic                          rd_en_sel,
    output logic [NUM_BRAM_ADDR_BITS:0]   occupancy,
    output logic                          overflow_err,
    output logic                          misroute_err,
    output logic [PAYLOAD_BITS-1:0]       input_port_stall_cnt
);

    localparam int DEPTH = 1 << NUM_BRAM_ADDR_BITS;
    localparam int CNT_W = NUM_BRAM_ADDR_BITS + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] FUS_C = CNT_W'(FREESPACE_UPDATE_SIZE);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_PEND = 1'b1
    } state_t;

    // packet fields
    logic                      w_vld;
    logic [NUM_LEAF_BITS-1:0]  w_dst_leaf;
    logic [NUM_PORT_BITS-1:0]  w_dst_port;
    logic [NUM_ADDR_BITS-1:0]  w_fifo_addr;
    logic [PAYLOAD_BITS-1:0]   w_payload;
    logic                      w_unused;

    logic                      w_match;
    logic                      w_full;
    logic                      w_pop;
    logic                      w_wr;

    logic [DATA_USER_IN-1:0]       r_mem [DEPTH];
    logic [NUM_BRAM_ADDR_BITS-1:0] r_wr_ptr;
    logic [NUM_BRAM_ADDR_BITS-1:0] r_rd_ptr;
    logic [CNT_W-1:0]              r_occ;
    logic                          r_overflow;
    logic                          r_misroute;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [CNT_W-1:0]          r_consumed;
    logic [CNT_W-1:0]          w_consumed_nxt;
    logic [CNT_W-1:0]          w_pop_inc;
    logic [PACKET_BITS-1:0]    r_out;
    logic [PACKET_BITS-1:0]    w_out_nxt;
    logic                      r_empty;
    logic                      w_empty_nxt;
    logic [PACKET_BITS-PAYLOAD_BITS-1:0] w_credit_hdr;

    assign w_vld       = internal_in[PACKET_BITS-1];
    assign w_dst_leaf  = internal_in[PACKET_BITS-2 -: NUM_LEAF_BITS];
    assign w_dst_port  = internal_in[PACKET_BITS-2-NUM_LEAF_BITS -: NUM_PORT_BITS];
    assign w_fifo_addr = internal_in[PAYLOAD_BITS +: NUM_ADDR_BITS];
    assign w_payload   = internal_in[PAYLOAD_BITS-1:0];

    // fifo_addr and the payload bits above the user width are not stored
    assign w_unused = ^{w_fifo_addr, w_payload[PAYLOAD_BITS-1:DATA_USER_IN]};

    assign w_match = w_vld
                   && (w_dst_leaf == self_leaf_reg)
                   && (w_dst_port == self_port_reg);
    assign w_full  = (r_occ == DEPTH_C);
    assign w_pop   = vld_interface2user && ack_user2interface;
    // a pop in the same cycle frees the slot a full buffer needs
    assign w_wr    = w_match && (!w_full || w_pop);

    assign vld_interface2user  = (r_occ != '0);
    assign dout_interface2user = r_mem[r_rd_ptr];
    assign occupancy           = r_occ;
    assign overflow_err        = r_overflow;
    assign misroute_err        = r_misroute;
    assign internal_out        = r_out;
    assign empty               = r_empty;

    // buffer storage, no reset needed
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= w_payload[DATA_USER_IN-1:0];
        end
    end

    // pointers, occupancy and sticky error flags
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_occ      <= '0;
            r_overflow <= 1'b0;
            r_misroute <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_wr, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
            if (w_match && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
            if (w_vld && !w_match) begin
                r_misroute <= 1'b1;
            end
        end
    end

    assign w_pop_inc    = {{(CNT_W-1){1'b0}}, w_pop};
    assign w_credit_hdr = {1'b1, src_leaf_reg, src_port_reg, {NUM_ADDR_BITS{1'b0}}};

    // credit FSM state, consumed count and outgoing packet
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_consumed <= '0;
            r_out      <= '0;
            r_empty    <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_consumed <= w_consumed_nxt;
            r_out      <= w_out_nxt;
            r_empty    <= w_empty_nxt;
        end
    end

    // credit FSM next state: full-size credits first, partial only on done
    always_comb begin
        w_state_nxt    = r_state;
        w_consumed_nxt = r_consumed + w_pop_inc;
        w_out_nxt      = r_out;
        w_empty_nxt    = r_empty;
        unique case (r_state)
            S_IDLE: begin
                if (r_consumed >= FUS_C) begin
                    w_out_nxt      = {w_credit_hdr,
                                      PAYLOAD_BITS'(FREESPACE_UPDATE_SIZE)};
                    w_consumed_nxt = r_consumed - FUS_C + w_pop_inc;
                    w_empty_nxt    = 1'b0;
                    w_state_nxt    = S_PEND;
                end else if (is_done_mode && (r_consumed != '0)) begin
                    w_out_nxt      = {w_credit_hdr, PAYLOAD_BITS'(r_consumed)};
                    w_consumed_nxt = w_pop_inc;
                    w_empty_nxt    = 1'b0;
                    w_state_nxt    = S_PEND;
                end
            end
            S_PEND: begin
                if (rd_en_sel) begin
                    w_out_nxt   = '0;
                    w_empty_nxt = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef INPUT_PORT_STALL_CNT_EN
    logic [PAYLOAD_BITS-1:0] r_stall;

    // count cycles where data is offered but the user holds off, saturating
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall <= '0;
        end else if (vld_interface2user && !ack_user2interface
                     && (r_stall != '1)) begin
            r_stall <= r_stall + 1'b1;
        end
    end

    assign input_port_stall_cnt = r_stall;
`else
    assign input_port_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_input_port_receiver.sv
// Directed bench for input_port_receiver with a data scoreboard.
// Stall-counter expectation follows INPUT_PORT_STALL_CNT_EN.
module tb_input_port_receiver;

    localparam int LB  = 6;
    localparam int PB  = 4;
    localparam int AB  = 7;
    localparam int PLB = 64;
    localparam int DU  = 32;
    localparam int PKB = 1 + LB + PB + AB + PLB;

    localparam logic [LB-1:0] SELF_LEAF = 6'h15;
    localparam logic [PB-1:0] SELF_PORT = 4'h9;
    localparam logic [LB-1:0] SRC_LEAF  = 6'h2A;
    localparam logic [PB-1:0] SRC_PORT  = 4'h3;

    logic           clk = 1'b0;
    logic           reset;
    logic [PKB-1:0] internal_in;
    logic [LB-1:0]  self_leaf_reg;
    logic [PB-1:0]  self_port_reg;
    logic [LB-1:0]  src_leaf_reg;
    logic [PB-1:0]  src_port_reg;
    logic           is_done_mode;
    logic [DU-1:0]  dout_interface2user;
    logic           vld_interface2user;
    logic           ack_user2interface;
    logic [PKB-1:0] internal_out;
    logic           empty;
    logic           rd_en_sel;
    logic [7:0]     occupancy;
    logic           overflow_err;
    logic           misroute_err;
    logic [PLB-1:0] input_port_stall_cnt;

    int checks = 0;
    int errors = 0;
    logic [DU-1:0] exp_q[$];
    logic [PKB-1:0] exp_pkt;

    input_port_receiver dut (
        .clk                  (clk),
        .reset                (reset),
        .internal_in          (internal_in),
        .self_leaf_reg        (self_leaf_reg),
        .self_port_reg        (self_port_reg),
        .src_leaf_reg         (src_leaf_reg),
        .src_port_reg         (src_port_reg),
        .is_done_mode         (is_done_mode),
        .dout_interface2user  (dout_interface2user),
        .vld_interface2user   (vld_interface2user),
        .ack_user2interface   (ack_user2interface),
        .internal_out         (internal_out),
        .empty                (empty),
        .rd_en_sel            (rd_en_sel),
        .occupancy            (occupancy),
        .overflow_err         (overflow_err),
        .misroute_err         (misroute_err),
        .input_port_stall_cnt (input_port_stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [PKB-1:0] pkt(input logic [LB-1:0] leaf,
                                           input logic [PB-1:0] port,
                                           input logic [DU-1:0] data);
        return {1'b1, leaf, port, 7'h55, ~data, data};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // pops compare against the scoreboard just before the edge that pops
    task automatic tick();
        @(negedge clk);
        if (vld_interface2user && ack_user2interface) begin
            if (exp_q.size() == 0) begin
                chk("sb_nonempty", 128'(exp_q.size()), 128'd1);
            end else begin
                chk("dout", 128'(dout_interface2user), 128'(exp_q.pop_front()));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DU-1:0] data, input bit accepted);
        internal_in = pkt(SELF_LEAF, SELF_PORT, data);
        if (accepted) exp_q.push_back(data);
        tick();
        internal_in = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        internal_in = '0;
        ack_user2interface = 1'b0;
        rd_en_sel = 1'b0;
        is_done_mode = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        self_leaf_reg = SELF_LEAF;
        self_port_reg = SELF_PORT;
        src_leaf_reg  = SRC_LEAF;
        src_port_reg  = SRC_PORT;
        do_reset();

        chk("rst_occ", 128'(occupancy), 128'd0);
        chk("rst_vld", 128'(vld_interface2user), 128'd0);
        chk("rst_empty", 128'(empty), 128'd1);
        chk("rst_out", 128'(internal_out), 128'd0);
        chk("rst_ovf", 128'(overflow_err), 128'd0);
        chk("rst_mis", 128'(misroute_err), 128'd0);
        chk("rst_stall", 128'(input_port_stall_cnt), 128'd0);

        // three packets streamed with ack held high
        ack_user2interface = 1'b1;
        send(32'hA, 1'b1);
        chk("t1_vld", 128'(vld_interface2user), 128'd1);
        chk("t1_headA", 128'(dout_interface2user), 128'hA);
        send(32'hB, 1'b1);
        send(32'hC, 1'b1);
        tick();
        chk("t1_occ0", 128'(occupancy), 128'd0);
        chk("t1_sb", 128'(exp_q.size()), 128'd0);
        ack_user2interface = 1'b0;

        // misrouted packet is dropped and flagged until reset
        do_reset();
        internal_in = pkt(SELF_LEAF, SELF_PORT ^ 4'h1, 32'h77);
        tick();
        internal_in = '0;
        chk("mis_occ", 128'(occupancy), 128'd0);
        chk("mis_vld", 128'(vld_interface2user), 128'd0);
        chk("mis_flag", 128'(misroute_err), 128'd1);
        tick();
        tick();
        chk("mis_sticky", 128'(misroute_err), 128'd1);
        chk("mis_ovf", 128'(overflow_err), 128'd0);
        do_reset();
        chk("mis_clr", 128'(misroute_err), 128'd0);

        // fill to full, overflow, then write+pop while full
        for (int i = 0; i < 128; i++) send(DU'(i), 1'b1);
        chk("full_occ", 128'(occupancy), 128'd128);
        chk("full_ovf0", 128'(overflow_err), 128'd0);
        send(32'hDEAD, 1'b0);
        chk("ovf_occ", 128'(occupancy), 128'd128);
        chk("ovf_flag", 128'(overflow_err), 128'd1);
        ack_user2interface = 1'b1;
        send(32'hBEEF, 1'b1);
        ack_user2interface = 1'b0;
        chk("wrpop_occ", 128'(occupancy), 128'd128);
        chk("ovf_sticky", 128'(overflow_err), 128'd1);
        ack_user2interface = 1'b1;
        for (int i = 0; i < 128; i++) tick();
        ack_user2interface = 1'b0;
        chk("drain_occ", 128'(occupancy), 128'd0);
        chk("drain_sb", 128'(exp_q.size()), 128'd0);

        // 64 pops produce one full-size credit
        do_reset();
        for (int i = 0; i < 70; i++) send(DU'(32'h1000 + i), 1'b1);
        ack_user2interface = 1'b1;
        for (int i = 0; i < 64; i++) tick();
        ack_user2interface = 1'b0;
        chk("cr_empty_pre", 128'(empty), 128'd1);
        tick();
        exp_pkt = {1'b1, SRC_LEAF, SRC_PORT, 7'd0, 64'd64};
        chk("cr_empty", 128'(empty), 128'd0);
        chk("cr_pkt", 128'(internal_out), 128'(exp_pkt));
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("cr_hold_pkt", 128'(internal_out), 128'(exp_pkt));
            chk("cr_hold_empty", 128'(empty), 128'd0);
        end
        rd_en_sel = 1'b1;
        tick();
        rd_en_sel = 1'b0;
        chk("cr_rel_empty", 128'(empty), 128'd1);
        chk("cr_rel_out", 128'(internal_out), 128'd0);
        chk("cr_occ", 128'(occupancy), 128'd6);

        // partial credit flushed by done mode
        do_reset();
        for (int i = 0; i < 10; i++) send(DU'(32'h2000 + i), 1'b1);
        ack_user2interface = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        ack_user2interface = 1'b0;
        tick();
        chk("done_idle", 128'(empty), 128'd1);
        is_done_mode = 1'b1;
        tick();
        is_done_mode = 1'b0;
        exp_pkt = {1'b1, SRC_LEAF, SRC_PORT, 7'd0, 64'd10};
        chk("done_empty", 128'(empty), 128'd0);
        chk("done_pkt", 128'(internal_out), 128'(exp_pkt));
        rd_en_sel = 1'b1;
        tick();
        rd_en_sel = 1'b0;
        is_done_mode = 1'b1;
        tick();
        tick();
        is_done_mode = 1'b0;
        chk("done_cnt0", 128'(empty), 128'd1);

        // user stalls for 7 cycles
        do_reset();
        send(32'h3333, 1'b1);
        for (int i = 0; i < 7; i++) tick();
`ifdef INPUT_PORT_STALL_CNT_EN
        chk("stall_cnt", 128'(input_port_stall_cnt), 128'd7);
`else
        chk("stall_cnt", 128'(input_port_stall_cnt), 128'd0);
`endif
        ack_user2interface = 1'b1;
        tick();
        ack_user2interface = 1'b0;
        chk("stall_sb", 128'(exp_q.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/input_port_receiver.md
Name: input_port_receiver

Overview:
Receiving end of the leaf output-port protocol. Accepts NoC packets addressed to this leaf/port and buffers them in a ring FIFO. Delivers the payloads to the user operator over a valid/ack handshake, and returns freespace credit packets to the upstream output port, one per FREESPACE_UPDATE_SIZE consumed words. Sits in the leaf interface between the leaf switch and the user operator's input stream.

Parameters:
NUM_LEAF_BITS, 6, leaf address width
NUM_PORT_BITS, 4, port address width
NUM_ADDR_BITS, 7, fifo_addr field width
PAYLOAD_BITS, 64, packet payload width
NUM_BRAM_ADDR_BITS, 7, buffer depth = 2^NUM_BRAM_ADDR_BITS (128 entries)
FREESPACE_UPDATE_SIZE, 64, consumed words per credit packet (1..depth)
DATA_USER_IN, 32, user data width (≤ PAYLOAD_BITS; payload low bits)
PACKET_BITS (localparam), 1+NUM_LEAF_BITS+NUM_PORT_BITS+NUM_ADDR_BITS+PAYLOAD_BITS

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
internal_in  in  PACKET_BITS  incoming packet, fields MSB→LSB {vld, dst_leaf, dst_port, fifo_addr, payload}
self_leaf_reg  in  NUM_LEAF_BITS  own leaf id
self_port_reg  in  NUM_PORT_BITS  own port id
src_leaf_reg  in  NUM_LEAF_BITS  upstream leaf for credit return
src_port_reg  in  NUM_PORT_BITS  upstream port for credit return
is_done_mode  in  1  flush partial credit
dout_interface2user  out  DATA_USER_IN  head data
vld_interface2user  out  1  head valid
ack_user2interface  in  1  user pops head
internal_out  out  PACKET_BITS  credit packet
empty  out  1  low = credit packet pending
rd_en_sel  in  1  switch consumes credit packet
occupancy  out  NUM_BRAM_ADDR_BITS+1  buffered words
overflow_err  out  1  sticky: write dropped, buffer full
misroute_err  out  1  sticky: leaf/port mismatch dropped
input_port_stall_cnt  out  PAYLOAD_BITS  user stall cycles (optional)

Behaviour:
- Single clock domain; synchronous active-high reset; all state registered.
- Reset: pointers, occupancy=0, vld_interface2user=0, empty=1, internal_out=0, errors=0, consumed count=0, FSM=IDLE, stall count=0.
- Accept: vld=1 and dst_leaf==self_leaf_reg and dst_port==self_port_reg. Payload written at wr_ptr; wr_ptr wraps modulo depth. fifo_addr ignored on receive.
- vld=1 with mismatch: drop; misroute_err set next cycle, held until reset.
- Full (occupancy==depth) and accept: if the same cycle pops (vld&ack), the write succeeds; otherwise drop and set overflow_err.
- FWFT read: vld_interface2user = (occupancy!=0); dout = payload[DATA_USER_IN-1:0] of head, combinational from buffer. Write in cycle N → visible in cycle N+1. Pop on vld&ack; ack with vld=0 is ignored.
- occupancy +1 on write, −1 on pop, unchanged when both occur.
- consumed count (width NUM_BRAM_ADDR_BITS+1) +1 per pop.
- Credit FSM:
  - IDLE: if consumed ≥ FREESPACE_UPDATE_SIZE → load internal_out={1, src_leaf_reg, src_port_reg, fifo_addr=0, payload=FREESPACE_UPDATE_SIZE}; consumed −= FREESPACE_UPDATE_SIZE (+1 if popping same cycle); empty←0; go PEND.
  - IDLE, else if is_done_mode and consumed>0 → same, payload=consumed; consumed←0 (+pop); go PEND.
  - PEND: hold internal_out stable; on rd_en_sel → empty←1, internal_out←0, go IDLE. rd_en_sel in IDLE is ignored.
- Credit emission latency: 1 cycle after threshold crossing.
- Consumption continues during PEND. At most one credit packet outstanding.

Optional Feature:
INPUT_PORT_STALL_CNT_EN: when defined, input_port_stall_cnt increments each cycle where vld_interface2user=1 and ack_user2interface=0, saturating at all-ones. When undefined, the port remains and is tied to 0.

Test Plan:
- 3 matching packets (payloads 0xA,0xB,0xC), ack held high → dout A,B,C on consecutive cycles starting 1 cycle after the first write; occupancy returns to 0.
- Packet with dst_port≠self_port_reg → not buffered, occupancy=0, misroute_err=1 until reset.
- Write 128 with no ack, then a 129th → occupancy=128, overflow_err=1. Write plus pop on the same cycle while full → accepted, occupancy stays 128.
- Pop 64 words → empty=0 one cycle later, internal_out payload=64 with src leaf/port. Hold rd_en_sel low 5 cycles → packet stable; rd_en_sel=1 → empty=1 next cycle.
- Pop 10 words, assert is_done_mode → credit payload=10, consumed count=0.
- Macro defined, vld=1 and ack=0 for 7 cycles → input_port_stall_cnt=7. Macro undefined → stays 0.
